// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter for the single register-file write port, with a busy scoreboard
// for issue-stage hazard checks. One cycle from grant to regWrite; the register file never stalls.
module rf_wb_arbiter #(
  parameter int NREQ = 2,
  parameter int XLEN = 32,
  parameter int NREG = 32,
  localparam int AW = $clog2(NREG),
  localparam int PW = $clog2(NREQ)
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_rsv_valid,
  input  logic [AW-1:0]        i_rsv_rd,
  input  logic [NREQ-1:0]      i_req_valid,
  input  logic [NREQ*AW-1:0]   i_req_rd,
  input  logic [NREQ*XLEN-1:0] i_req_dat,
  output logic [NREQ-1:0]      o_req_ready,
  output logic                 o_regWrite,
  output logic [AW-1:0]        o_rd,
  output logic [XLEN-1:0]      o_reg_wr_dat,
  input  logic [AW-1:0]        i_rs1,
  input  logic [AW-1:0]        i_rs2,
  output logic                 o_rs1_busy,
  output logic                 o_rs2_busy,
  output logic                 o_err_unrsv
);

  logic [PW-1:0]   r_rr_ptr;
  logic [NREG-1:0] r_busy;
  logic            r_regwrite;
  logic [AW-1:0]   r_rd;
  logic [XLEN-1:0] r_dat;
  logic            r_err;

  logic            w_gnt_vld;
  logic [PW-1:0]   w_gnt_idx;
  logic [AW-1:0]   w_gnt_rd;
  logic [XLEN-1:0] w_gnt_dat;
  int              w_idx;

  // Scan from rr_ptr upward, wrapping, and take the first valid requester.
  always_comb begin
    w_gnt_vld   = 1'b0;
    w_gnt_idx   = '0;
    w_idx       = 0;
    o_req_ready = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = int'(r_rr_ptr) + k;
      if (w_idx >= NREQ) w_idx = w_idx - NREQ;
      if (!w_gnt_vld && i_req_valid[w_idx]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = PW'(w_idx);
      end
    end
    if (w_gnt_vld) o_req_ready[w_gnt_idx] = 1'b1;
  end

  assign w_gnt_rd  = i_req_rd[int'(w_gnt_idx)*AW +: AW];
  assign w_gnt_dat = i_req_dat[int'(w_gnt_idx)*XLEN +: XLEN];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rr_ptr   <= '0;
      r_regwrite <= 1'b0;
      r_rd       <= '0;
      r_dat      <= '0;
    end else begin
      r_regwrite <= w_gnt_vld && (w_gnt_rd != '0);
      if (w_gnt_vld) begin
        r_rd     <= w_gnt_rd;
        r_dat    <= w_gnt_dat;
        r_rr_ptr <= (w_gnt_idx == PW'(NREQ-1)) ? '0 : w_gnt_idx + PW'(1);
      end
    end
  end

  // The reservation update comes last so a same-edge set beats the write-back clear.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_busy <= '0;
      r_err  <= 1'b0;
    end else begin
      if (w_gnt_vld && (w_gnt_rd != '0)) begin
        r_busy[w_gnt_rd] <= 1'b0;
        if (!r_busy[w_gnt_rd]) r_err <= 1'b1;
      end
      if (i_rsv_valid && (i_rsv_rd != '0)) r_busy[i_rsv_rd] <= 1'b1;
    end
  end

  assign o_regWrite   = r_regwrite;
  assign o_rd         = r_rd;
  assign o_reg_wr_dat = r_dat;
  assign o_err_unrsv  = r_err;

  // The output-stage term covers a write still one cycle away from the register file.
  assign o_rs1_busy = (i_rs1 != '0) && (r_busy[i_rs1] || (r_regwrite && (r_rd == i_rs1)));
  assign o_rs2_busy = (i_rs2 != '0) && (r_busy[i_rs2] || (r_regwrite && (r_rd == i_rs2)));

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed scenarios plus a randomized run against a reference model.
module tb_rf_wb_arbiter;
  localparam int NREQ = 2;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                 rsv_v;
  logic [AW-1:0]        rsv_rd;
  logic [NREQ-1:0]      req_v;
  logic [NREQ*AW-1:0]   req_rd;
  logic [NREQ*XLEN-1:0] req_dat;
  logic [NREQ-1:0]      ready;
  logic                 we;
  logic [AW-1:0]        rd;
  logic [XLEN-1:0]      dat;
  logic [AW-1:0]        rs1, rs2;
  logic                 b1, b2, err;

  int n_chk = 0;
  int n_pass = 0;

  bit          m_busy[NREG];
  int          m_ptr;
  bit          m_we;
  int          m_rd;
  logic [31:0] m_dat;
  bit          m_err;

  rf_wb_arbiter dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_rsv_valid(rsv_v), .i_rsv_rd(rsv_rd),
    .i_req_valid(req_v), .i_req_rd(req_rd), .i_req_dat(req_dat),
    .o_req_ready(ready),
    .o_regWrite(we), .o_rd(rd), .o_reg_wr_dat(dat),
    .i_rs1(rs1), .i_rs2(rs2),
    .o_rs1_busy(b1), .o_rs2_busy(b2),
    .o_err_unrsv(err)
  );

  function automatic int exp_grant();
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (m_ptr + k) % NREQ;
      if (req_v[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] exp_ready();
    logic [NREQ-1:0] r;
    int g;
    r = '0;
    g = exp_grant();
    if (g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  function automatic logic exp_busy(logic [AW-1:0] rs);
    return (rs != 0) && (m_busy[rs] || (m_we && m_rd == int'(rs)));
  endfunction

  task automatic model_reset();
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    m_ptr = 0; m_we = 1'b0; m_rd = 0; m_dat = '0; m_err = 1'b0;
  endtask

  // Advance one clock edge, updating the model from the inputs present before it.
  task automatic tick();
    int g;
    int grd;
    logic [31:0] gd;
    g = exp_grant();
    grd = 0;
    gd = '0;
    if (g >= 0) begin
      grd = int'(req_rd[g*AW +: AW]);
      gd  = req_dat[g*XLEN +: XLEN];
    end
    @(posedge clk);
    if (g >= 0) begin
      if (grd != 0 && !m_busy[grd]) m_err = 1'b1;
      if (grd != 0) m_busy[grd] = 1'b0;
      m_we  = (grd != 0);
      m_rd  = grd;
      m_dat = gd;
      m_ptr = (g + 1) % NREQ;
    end else begin
      m_we = 1'b0;
    end
    if (rsv_v && rsv_rd != 0) m_busy[rsv_rd] = 1'b1;
    #1;
  endtask

  task automatic idle();
    rsv_v = 1'b0;
    req_v = '0;
  endtask

  task automatic set_req(int i, int r, logic [31:0] d);
    req_v[i] = 1'b1;
    req_rd[i*AW +: AW] = AW'(r);
    req_dat[i*XLEN +: XLEN] = d;
  endtask

  task automatic test_reset();
    n_chk++; if (we !== 1'b0) $display("FAIL reset_we got %b want 0", we); else n_pass++;
    n_chk++; if (rd !== '0) $display("FAIL reset_rd got %0d want 0", rd); else n_pass++;
    n_chk++; if (dat !== '0) $display("FAIL reset_dat got %h want 0", dat); else n_pass++;
    n_chk++; if (err !== 1'b0) $display("FAIL reset_err got %b want 0", err); else n_pass++;
    n_chk++; if (ready !== 2'b00) $display("FAIL reset_ready got %b want 00", ready); else n_pass++;
  endtask

  task automatic test_single();
    idle(); rsv_v = 1'b1; rsv_rd = 5; tick();
    idle(); set_req(0, 5, 32'hDEADBEEF); rs1 = 5; #1;
    n_chk++; if (ready !== 2'b01) $display("FAIL single_ready got %b want 01", ready); else n_pass++;
    n_chk++; if (b1 !== 1'b1) $display("FAIL single_busy_pre got %b want 1", b1); else n_pass++;
    tick(); idle(); #1;
    n_chk++; if (we !== 1'b1) $display("FAIL single_we got %b want 1", we); else n_pass++;
    n_chk++; if (rd !== 5'd5) $display("FAIL single_rd got %0d want 5", rd); else n_pass++;
    n_chk++; if (dat !== 32'hDEADBEEF) $display("FAIL single_dat got %h want deadbeef", dat); else n_pass++;
    n_chk++; if (b1 !== 1'b1) $display("FAIL single_busy_wb got %b want 1", b1); else n_pass++;
    tick();
    n_chk++; if (b1 !== 1'b0) $display("FAIL single_busy_after got %b want 0", b1); else n_pass++;
    n_chk++; if (we !== 1'b0) $display("FAIL single_we_after got %b want 0", we); else n_pass++;
  endtask

  task automatic test_x0();
    idle(); set_req(1, 0, 32'h1234); #1;
    n_chk++; if (ready !== 2'b10) $display("FAIL x0_ready got %b want 10", ready); else n_pass++;
    tick(); idle(); #1;
    n_chk++; if (we !== 1'b0) $display("FAIL x0_we got %b want 0", we); else n_pass++;
    n_chk++; if (err !== 1'b0) $display("FAIL x0_err got %b want 0", err); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [NREQ-1:0] want_rdy [4];
    int want_rd [4];
    want_rdy = '{2'b01, 2'b10, 2'b01, 2'b10};
    want_rd  = '{1, 2, 3, 4};
    for (int r = 1; r <= 4; r++) begin
      rsv_v = 1'b1; rsv_rd = AW'(r); tick();
    end
    idle();
    set_req(0, 1, 32'hA0000001);
    set_req(1, 2, 32'hB0000002);
    for (int k = 0; k < 4; k++) begin
      #1;
      n_chk++; if (ready !== want_rdy[k]) $display("FAIL b2b_ready[%0d] got %b want %b", k, ready, want_rdy[k]); else n_pass++;
      tick();
      n_chk++; if (we !== 1'b1 || rd !== AW'(want_rd[k])) $display("FAIL b2b_wr[%0d] got we=%b rd=%0d want we=1 rd=%0d", k, we, rd, want_rd[k]); else n_pass++;
      if (k == 0) set_req(0, 3, 32'hA0000003);
      if (k == 1) set_req(1, 4, 32'hB0000004);
    end
    idle(); tick();
    n_chk++; if (we !== 1'b0) $display("FAIL b2b_end_we got %b want 0", we); else n_pass++;
    n_chk++; if (err !== 1'b0) $display("FAIL b2b_err got %b want 0", err); else n_pass++;
  endtask

  task automatic test_set_wins();
    idle(); rsv_v = 1'b1; rsv_rd = 7; tick();
    set_req(0, 7, 32'h77); tick();
    idle(); rs1 = 7; tick();
    n_chk++; if (b1 !== 1'b1) $display("FAIL setwins_busy got %b want 1", b1); else n_pass++;
    n_chk++; if (err !== 1'b0) $display("FAIL setwins_err got %b want 0", err); else n_pass++;
    set_req(0, 7, 32'h78); tick(); idle(); tick();
    n_chk++; if (b1 !== 1'b0) $display("FAIL setwins_clear got %b want 0", b1); else n_pass++;
  endtask

  task automatic test_err();
    idle(); set_req(0, 9, 32'h99); tick(); idle(); #1;
    n_chk++; if (we !== 1'b1 || rd !== 5'd9) $display("FAIL err_wr got we=%b rd=%0d want we=1 rd=9", we, rd); else n_pass++;
    n_chk++; if (err !== 1'b1) $display("FAIL err_set got %b want 1", err); else n_pass++;
    repeat (3) tick();
    n_chk++; if (err !== 1'b1) $display("FAIL err_sticky got %b want 1", err); else n_pass++;
  endtask

  task automatic test_random();
    int g;
    idle();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req_v[i] && $urandom_range(0, 2) != 0) begin
          set_req(i, ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, NREG-1)), $urandom);
        end
      end
      rsv_v  = ($urandom_range(0, 1) == 1);
      rsv_rd = AW'($urandom_range(0, NREG-1));
      rs1    = AW'($urandom_range(0, NREG-1));
      rs2    = (c % 3 == 0) ? rd : AW'($urandom_range(0, NREG-1));
      #1;
      n_chk++; if (ready !== exp_ready()) $display("FAIL rnd_ready c=%0d got %b want %b", c, ready, exp_ready()); else n_pass++;
      n_chk++; if (b1 !== exp_busy(rs1)) $display("FAIL rnd_rs1 c=%0d rs=%0d got %b want %b", c, rs1, b1, exp_busy(rs1)); else n_pass++;
      n_chk++; if (b2 !== exp_busy(rs2)) $display("FAIL rnd_rs2 c=%0d rs=%0d got %b want %b", c, rs2, b2, exp_busy(rs2)); else n_pass++;
      g = exp_grant();
      tick();
      if (g >= 0) req_v[g] = 1'b0;
      n_chk++; if (we !== m_we || rd !== AW'(m_rd) || dat !== m_dat)
        $display("FAIL rnd_out c=%0d got we=%b rd=%0d dat=%h want we=%b rd=%0d dat=%h", c, we, rd, dat, m_we, m_rd, m_dat);
      else n_pass++;
      n_chk++; if (err !== m_err) $display("FAIL rnd_err c=%0d got %b want %b", c, err, m_err); else n_pass++;
    end
    idle();
  endtask

  task automatic test_reset_mid();
    idle(); rsv_v = 1'b1; rsv_rd = 5; set_req(0, 3, 32'h33); tick();
    idle(); rs1 = 5; #1;
    n_chk++; if (b1 !== 1'b1 || we !== 1'b1) $display("FAIL rstmid_pre got busy=%b we=%b want 1 1", b1, we); else n_pass++;
    rst_n = 1'b0; #1;
    model_reset();
    n_chk++; if (we !== 1'b0 || rd !== '0 || dat !== '0) $display("FAIL rstmid_out got we=%b rd=%0d dat=%h want 0", we, rd, dat); else n_pass++;
    n_chk++; if (err !== 1'b0) $display("FAIL rstmid_err got %b want 0", err); else n_pass++;
    n_chk++; if (b1 !== 1'b0) $display("FAIL rstmid_busy got %b want 0", b1); else n_pass++;
    rsv_v = 1'b1; rsv_rd = 5; set_req(0, 6, 32'h66);
    @(posedge clk); #1;
    n_chk++; if (b1 !== 1'b0 || we !== 1'b0) $display("FAIL rstmid_hold got busy=%b we=%b want 0 0", b1, we); else n_pass++;
    idle(); rst_n = 1'b1; #1;
  endtask

  initial begin
    rsv_v = 1'b0; rsv_rd = '0; req_v = '0; req_rd = '0; req_dat = '0;
    rs1 = '0; rs2 = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    tick();
    test_single();
    test_x0();
    test_back_to_back();
    test_set_wins();
    test_err();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
